// File: rtl/mdu_seq_if.sv
// mdu_seq_if: execute-stage <-> M-extension sequencer bundle.
//   master (ex stage): drives start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i
//   slave  (mdu_seq) : drives busy_o, hold_o, done_o, result_o, rd_addr_o, reg_wen_o
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            busy_o;
    logic            hold_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;
    logic            reg_wen_o;

    modport master (
        output start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  busy_o, hold_o, done_o, result_o, rd_addr_o, reg_wen_o
    );

    modport slave (
        input  start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        output busy_o, hold_o, done_o, result_o, rd_addr_o, reg_wen_o
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M sequencer sitting beside the ALU in ex.
// Radix-2 shift-add multiply / restoring divide on operand magnitudes,
// sign fixup on the way into DONE, one-cycle write-back pulse.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  start/func3/op1/op2/rd/flush in; busy/hold/done/result/rd/wen out
// Optional: define MDU_FAST_MUL_EN for a single-cycle combinational
// multiplier; divide always uses the iterative path.
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        func3_q;
    logic [4:0]        rd_q;
    logic              sign1_q, sign2_q;
    logic [XLEN-1:0]   opnd_q;      // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] acc;         // {hi, multiplier} or {remainder, quotient}
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   result_q;

    logic accept, special, fin;

    // ---- issue-side decode on raw inputs ----
    logic            sgn1_mode, sgn2_mode, neg1, neg2, div_by0, div_ovf;
    logic [XLEN-1:0] abs1, abs2, spec_res;

    always_comb begin
        sgn1_mode = (bus.func3_i == 3'b001) || (bus.func3_i == 3'b010) ||
                    (bus.func3_i == 3'b100) || (bus.func3_i == 3'b110);
        sgn2_mode = (bus.func3_i == 3'b001) || (bus.func3_i == 3'b100) ||
                    (bus.func3_i == 3'b110);
        neg1      = sgn1_mode && bus.op1_i[XLEN-1];
        neg2      = sgn2_mode && bus.op2_i[XLEN-1];
        abs1      = neg1 ? -bus.op1_i : bus.op1_i;
        abs2      = neg2 ? -bus.op2_i : bus.op2_i;
        div_by0   = bus.func3_i[2] && (bus.op2_i == '0);
        div_ovf   = bus.func3_i[2] && !bus.func3_i[0] &&
                    (bus.op1_i == MIN_NEG) && (bus.op2_i == '1);
        // by-zero: quotient all ones, remainder = dividend
        // overflow: quotient = dividend (MIN_NEG), remainder 0
        if (div_by0) spec_res = bus.func3_i[1] ? bus.op1_i : '1;
        else         spec_res = bus.func3_i[1] ? '0 : bus.op1_i;
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN-1:0] fm_p;
    logic [XLEN-1:0]          fast_res;
    always_comb begin
        fm_a     = {sgn1_mode & bus.op1_i[XLEN-1], bus.op1_i};
        fm_b     = {sgn2_mode & bus.op2_i[XLEN-1], bus.op2_i};
        fm_p     = fm_a * fm_b;
        fast_res = (bus.func3_i[1:0] == 2'b00) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
`endif

    // ---- one iteration of the datapath ----
    logic [XLEN:0]     mul_sum, shl, diff;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   quot, rem, fix_res;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        shl     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = shl - {1'b0, opnd_q};
        if (func3_q[2]) begin
            // diff[XLEN] is the borrow: restore on borrow, else keep difference
            step = diff[XLEN] ? {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        end
        prod = (sign1_q ^ sign2_q) ? -step : step;
        quot = (sign1_q ^ sign2_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = sign1_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (func3_q[2])                fix_res = func3_q[1] ? rem : quot;
        else if (func3_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
        else                            fix_res = prod[2*XLEN-1:XLEN];
    end

    // ---- FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        special    = 1'b0;
        fin        = 1'b0;
        bus.hold_o = 1'b0;
        bus.done_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    accept     = 1'b1;
                    bus.hold_o = 1'b1;
                    special    = div_by0 || div_ovf;
`ifdef MDU_FAST_MUL_EN
                    if (!bus.func3_i[2]) special = 1'b1;
`endif
                    state_nxt  = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                bus.hold_o = 1'b1;
                fin        = (cnt == CNT_W'(XLEN-1));
                if (fin) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // flush wins everywhere: abort, drop the write-back, release the stall
        if (bus.flush_i) begin
            state_nxt  = S_IDLE;
            accept     = 1'b0;
            special    = 1'b0;
            fin        = 1'b0;
            bus.hold_o = 1'b0;
            bus.done_o = 1'b0;
        end
    end

    // ---- datapath registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func3_q  <= '0;
            rd_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            opnd_q   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            func3_q <= bus.func3_i;
            rd_q    <= bus.rd_addr_i;
            sign1_q <= neg1;
            sign2_q <= neg2;
            cnt     <= '0;
            // dividend / multiplier go in the low half, the other operand in opnd_q
            acc     <= {{XLEN{1'b0}}, bus.func3_i[2] ? abs1 : abs2};
            opnd_q  <= bus.func3_i[2] ? abs2 : abs1;
`ifdef MDU_FAST_MUL_EN
            if (!bus.func3_i[2]) result_q <= fast_res;
            else if (special)    result_q <= spec_res;
`else
            if (special) result_q <= spec_res;
`endif
        end else if (state == S_CALC && !bus.flush_i) begin
            acc <= step;
            cnt <= cnt + 1'b1;
            if (fin) result_q <= fix_res;
        end
    end

    assign bus.busy_o    = (state != S_IDLE);
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_q;
    assign bus.reg_wen_o = bus.done_o && (rd_q != 5'd0);
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed + randomized checks of mdu_seq against a 64-bit
// arithmetic reference of the RV32M rules.
module tb_mdu_seq;
    logic clk, rst_n;
    int   checks   = 0;
    int   failures = 0;

    mdu_seq_if #(.XLEN(32)) bus();
    mdu_seq #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed with wide arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return 32'(int'(a) / int'(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait (bounded) for done_o, check everything at the DONE cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit keep_start, input string tag);
        int          lat;
        bit          hold_ok;
        logic [31:0] exp;
        exp = ref_res(f, a, b);
        @(negedge clk);
        chk({tag, ".idle_done"}, 32'(bus.done_o), 32'd0);
        bus.start_i   = 1'b1;
        bus.func3_i   = f;
        bus.op1_i     = a;
        bus.op2_i     = b;
        bus.rd_addr_i = rd;
        #1;
        chk({tag, ".issue_hold"}, 32'(bus.hold_o), 32'd1);
        @(negedge clk);
        if (keep_start) begin
            bus.op1_i   = ~a;
            bus.op2_i   = b ^ 32'h5;
            bus.func3_i = f ^ 3'b100;
        end else begin
            bus.start_i = 1'b0;
        end
        lat     = 1;
        hold_ok = 1'b1;
        while (bus.done_o !== 1'b1 && lat < 40) begin
            if (bus.hold_o !== 1'b1 || bus.busy_o !== 1'b1) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.start_i = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat(f, a, b)));
        chk({tag, ".result"}, bus.result_o, exp);
        chk({tag, ".rd"}, 32'(bus.rd_addr_o), 32'(rd));
        chk({tag, ".wen"}, 32'(bus.reg_wen_o), 32'(rd != 5'd0));
        chk({tag, ".done_hold"}, 32'(bus.hold_o), 32'd0);
        chk({tag, ".calc_hold"}, 32'(hold_ok), 32'd1);
    endtask

    initial begin
        bit seen;
        rst_n         = 1'b0;
        bus.start_i   = 1'b0;
        bus.func3_i   = '0;
        bus.op1_i     = '0;
        bus.op2_i     = '0;
        bus.rd_addr_i = '0;
        bus.flush_i   = 1'b0;
        #12;
        chk("rst.busy", 32'(bus.busy_o), 32'd0);
        chk("rst.done", 32'(bus.done_o), 32'd0);
        chk("rst.wen", 32'(bus.reg_wen_o), 32'd0);
        chk("rst.result", bus.result_o, 32'd0);
        chk("rst.rd", 32'(bus.rd_addr_o), 32'd0);
        chk("rst.hold", 32'(bus.hold_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0, "rem");
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0, "divu");
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0, "remu");
        run_op(3'd4, 32'd5, 32'd0, 5'd9, 1'b0, "div_by0");
        run_op(3'd7, 32'd5, 32'd0, 5'd10, 1'b0, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, "rem_ovf");
        run_op(3'd0, 32'd12345, 32'd678, 5'd13, 1'b1, "mul_keep");

        // flush partway through CALC
        @(negedge clk);
        bus.start_i = 1'b1; bus.func3_i = 3'd5; bus.op1_i = 32'd50; bus.op2_i = 32'd3;
        bus.rd_addr_i = 5'd14;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("flush.hold", 32'(bus.hold_o), 32'd0);
        chk("flush.done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush.busy", 32'(bus.busy_o), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) seen = 1'b1;
        end
        chk("flush.no_done", 32'(seen), 32'd0);
        run_op(3'd5, 32'd9, 32'd3, 5'd0, 1'b0, "divu_rd0");

        // flush landing on the DONE cycle
        @(negedge clk);
        bus.start_i = 1'b1; bus.func3_i = 3'd4; bus.op1_i = 32'd5; bus.op2_i = 32'd0;
        bus.rd_addr_i = 5'd7;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("dflush.pre_done", 32'(bus.done_o), 32'd1);
        bus.flush_i = 1'b1;
        #1;
        chk("dflush.done", 32'(bus.done_o), 32'd0);
        chk("dflush.wen", 32'(bus.reg_wen_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("dflush.busy", 32'(bus.busy_o), 32'd0);

        // randomized ops against the reference
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // reset in the middle of CALC
        @(negedge clk);
        bus.start_i = 1'b1; bus.func3_i = 3'd5; bus.op1_i = 32'd1000; bus.op2_i = 32'd9;
        bus.rd_addr_i = 5'd21;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.busy", 32'(bus.busy_o), 32'd0);
        chk("mrst.done", 32'(bus.done_o), 32'd0);
        chk("mrst.wen", 32'(bus.reg_wen_o), 32'd0);
        chk("mrst.result", bus.result_o, 32'd0);
        chk("mrst.rd", 32'(bus.rd_addr_o), 32'd0);
        chk("mrst.hold", 32'(bus.hold_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd22, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
